// File: rtl/ram_wb_pkg.sv
// Shared types and defaults for the core data-RAM to Wishbone classic bridge.
package ram_wb_pkg;

  localparam int               DEF_ADDR_W   = 32;
  localparam int               DEF_DATA_W   = 32;
  localparam logic [31:0]      DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Bus-side state: either idle (cyc low) or waiting for the slave's ack.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // One byte-enable per data byte.
  function automatic int sel_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_wb_req_buf.sv
// One-entry request buffer: holds a request the core issued while the bus was busy.
module ram_wb_req_buf #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Occupancy flag: set on push into an empty slot, cleared when the bridge issues it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
    end else if (i_push && !r_valid) begin
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  // Payload capture.
  // NOTE: the payload has no reset; it is only ever read while r_valid is set,
  // so resetting it would add reset fan-out without changing behaviour.
  always_ff @(posedge clk_i) begin
    if (i_push && !r_valid) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ready = ~r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ram_wb_bridge.sv
// Core data-RAM port to Wishbone classic master: one bus cycle at a time, a one-entry
// pending buffer for requests issued while busy, and a timeout that retires hung cycles.
module ram_wb_bridge
  import ram_wb_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                TIMEOUT  = 255,
  parameter int                CNT_W    = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA),
  localparam int               SEL_W    = sel_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ram_ce_i,
  output logic              ram_ready_o,
  input  logic              ram_we_i,
  input  logic [SEL_W-1:0]  ram_sel_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [DATA_W-1:0] ram_rdata_o,
  output logic              ram_rvalid_o,
  output logic              ram_err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_ack_i
);

  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [SEL_W-1:0]   r_sel;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;
  logic               r_err;

  req_t w_live, w_pend, w_src;
  logic w_pend_valid, w_buf_ready, w_accept, w_push, w_pop;
  logic w_launch, w_done, w_timeout;

  // Word-align the address up front; the bus never sees the byte offset.
  assign w_live = '{we:   ram_we_i,
                    sel:  ram_sel_i,
                    addr: ram_addr_i & ~ADDR_W'(3),
                    data: ram_data_i};

  assign w_accept = ram_ce_i & w_buf_ready;
  // While the bus is busy an accepted request parks in the buffer.
  assign w_push   = w_accept & (r_state == WAIT);

  ram_wb_req_buf #(.W($bits(req_t))) u_req_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_live),
    .i_pop   (w_pop),
    .o_valid (w_pend_valid),
    .o_ready (w_buf_ready),
    .o_data  (w_pend)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control: launch, completion and timeout decisions.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_src       = w_live;
    w_launch    = 1'b0;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pend_valid) begin
          w_src    = w_pend;
          w_launch = 1'b1;
          w_pop    = 1'b1;
        end else if (w_accept) begin
          w_launch = 1'b1;
        end
        if (w_launch) w_state_nxt = WAIT;
      end
      WAIT: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (wb_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus latches, timeout counter and the response pulses back to the core.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      if (w_launch) begin
        r_we    <= w_src.we;
        r_sel   <= w_src.sel;
        r_addr  <= w_src.addr;
        r_wdata <= w_src.data;
        r_cnt   <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done && !r_we) begin
        r_rdata  <= wb_data_i;
        r_rvalid <= 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
        if (!r_we) begin
          r_rdata  <= ERR_DATA;
          r_rvalid <= 1'b1;
        end
      end
    end
  end

  assign ram_ready_o  = w_buf_ready;
  assign ram_rdata_o  = r_rdata;
  assign ram_rvalid_o = r_rvalid;
  assign ram_err_o    = r_err;
  assign wb_cyc_o     = (r_state == WAIT);
  assign wb_stb_o     = (r_state == WAIT);
  assign wb_we_o      = r_we;
  assign wb_sel_o     = r_sel;
  assign wb_addr_o    = r_addr;
  assign wb_data_o    = r_wdata;

endmodule

// File: tb/tb_ram_wb_bridge.sv
// Directed bench for ram_wb_bridge: per-cycle {inputs, expected outputs} vectors.
module tb_ram_wb_bridge;

  logic        clk_i;
  logic        rst_i;
  logic        ram_ce_i;
  logic        ram_ready_o;
  logic        ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_rdata_o;
  logic        ram_rvalid_o;
  logic        ram_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  ram_wb_bridge #(.TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ram_ce_i     (ram_ce_i),
    .ram_ready_o  (ram_ready_o),
    .ram_we_i     (ram_we_i),
    .ram_sel_i    (ram_sel_i),
    .ram_addr_i   (ram_addr_i),
    .ram_data_i   (ram_data_i),
    .ram_rdata_o  (ram_rdata_o),
    .ram_rvalid_o (ram_rvalid_o),
    .ram_err_o    (ram_err_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_data_i    (wb_data_i),
    .wb_ack_i     (wb_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rst;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] wbd;
  } in_t;

  // Bus fields are compared only when cyc is expected high; rd only when rvalid is.
  typedef struct packed {
    logic        rdy;
    logic        cyc;
    logic        rv;
    logic        err;
    logic [31:0] rd;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wd;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   row   = 0;
  in_t  nop;
  in_t  rst_row;
  exp_t idl;

  function automatic in_t di(input logic ce, input logic we, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic ack, input logic [31:0] wbd);
    return in_t'{1'b0, ce, we, sel, addr, wd, ack, wbd};
  endfunction

  function automatic exp_t bus(input logic rdy, input logic we, input logic [3:0] sel,
                               input logic [31:0] addr, input logic [31:0] wd);
    return exp_t'{rdy, 1'b1, 1'b0, 1'b0, 32'h0, we, sel, addr, wd};
  endfunction

  function automatic exp_t resp(input logic rdy, input logic rv, input logic err,
                                input logic [31:0] rd);
    return exp_t'{rdy, 1'b0, rv, err, rd, 1'b0, 4'h0, 32'h0, 32'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h, expected %h", row, name, act, exp);
    end
  endtask

  task automatic add(input in_t vi, input exp_t ve);
    tbl.push_back(vec_t'{vi, ve});
  endtask

  // One cycle: drive inputs for the coming edge, then compare the registered outputs.
  task automatic step(input in_t vi, input exp_t ve);
    @(negedge clk_i);
    row++;
    rst_i      = vi.rst;
    ram_ce_i   = vi.ce;
    ram_we_i   = vi.we;
    ram_sel_i  = vi.sel;
    ram_addr_i = vi.addr;
    ram_data_i = vi.wd;
    wb_ack_i   = vi.ack;
    wb_data_i  = vi.wbd;
    check("ready",  {31'h0, ram_ready_o},  {31'h0, ve.rdy});
    check("cyc",    {31'h0, wb_cyc_o},     {31'h0, ve.cyc});
    check("stb",    {31'h0, wb_stb_o},     {31'h0, ve.cyc});
    check("rvalid", {31'h0, ram_rvalid_o}, {31'h0, ve.rv});
    check("err",    {31'h0, ram_err_o},    {31'h0, ve.err});
    if (ve.cyc) begin
      check("wb_we",   {31'h0, wb_we_o}, {31'h0, ve.we});
      check("wb_sel",  {28'h0, wb_sel_o}, {28'h0, ve.sel});
      check("wb_addr", wb_addr_o, ve.addr);
      check("wb_data", wb_data_o, ve.wd);
    end
    if (ve.rv) check("rdata", ram_rdata_o, ve.rd);
  endtask

  initial begin
    nop     = di(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_row = nop;
    rst_row.rst = 1'b1;
    idl     = resp(1'b1, 1'b0, 1'b0, 32'h0);

    // Plain read, ack two cycles after cyc rises.
    add(di(1, 0, 4'hF, 32'h0000_0104, 32'h0, 0, 32'h0), idl);
    add(nop, bus(1, 0, 4'hF, 32'h0000_0104, 32'h0));
    add(nop, bus(1, 0, 4'hF, 32'h0000_0104, 32'h0));
    add(di(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hCAFE_0001), bus(1, 0, 4'hF, 32'h0000_0104, 32'h0));
    add(nop, resp(1, 1, 0, 32'hCAFE_0001));
    // Unaligned write: byte offset dropped, lanes forwarded, no rvalid.
    add(di(1, 1, 4'b0010, 32'h0000_0013, 32'h0000_AB00, 0, 32'h0), idl);
    add(di(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hFFFF_FFFF), bus(1, 1, 4'b0010, 32'h0000_0010, 32'h0000_AB00));
    add(nop, idl);
    // Ack while idle is ignored.
    add(di(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h1111_1111), idl);
    add(nop, idl);
    // Zero byte enables are forwarded unchanged.
    add(di(1, 1, 4'h0, 32'h0000_0AB7, 32'h0000_0055, 0, 32'h0), idl);
    add(di(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0), bus(1, 1, 4'h0, 32'h0000_0AB4, 32'h0000_0055));
    add(nop, idl);
    // Read timeout: four WAIT cycles, then err + rvalid with the error pattern.
    add(di(1, 0, 4'hF, 32'h0000_0400, 32'h0, 0, 32'h0), idl);
    for (int k = 0; k < 4; k++) add(nop, bus(1, 0, 4'hF, 32'h0000_0400, 32'h0));
    add(nop, resp(1, 1, 1, 32'hDEAD_BEEF));
    add(nop, idl);
    // Write timeout: err only.
    add(di(1, 1, 4'hF, 32'h0000_0500, 32'h0000_5050, 0, 32'h0), idl);
    for (int k = 0; k < 4; k++) add(nop, bus(1, 1, 4'hF, 32'h0000_0500, 32'h0000_5050));
    add(nop, resp(1, 0, 1, 32'h0));
    add(nop, idl);
    // Ack in the cycle the timeout would fire: normal completion.
    add(di(1, 0, 4'hF, 32'h0000_0600, 32'h0, 0, 32'h0), idl);
    for (int k = 0; k < 3; k++) add(nop, bus(1, 0, 4'hF, 32'h0000_0600, 32'h0));
    add(di(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h5555_AAAA), bus(1, 0, 4'hF, 32'h0000_0600, 32'h0));
    add(nop, resp(1, 1, 0, 32'h5555_AAAA));
    add(nop, idl);

    // Reset state.
    rst_i = 1'b1; ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_sel_i = '0;
    ram_addr_i = '0; ram_data_i = '0; wb_ack_i = 1'b0; wb_data_i = '0;
    repeat (2) @(posedge clk_i);
    step(rst_row, idl);
    check("rst_wb_we",   {31'h0, wb_we_o}, 32'h0);
    check("rst_wb_sel",  {28'h0, wb_sel_o}, 32'h0);
    check("rst_wb_addr", wb_addr_o, 32'h0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_rdata",   ram_rdata_o, 32'h0);
    step(nop, idl);

    foreach (tbl[k]) step(tbl[k].i, tbl[k].e);

    // Back-to-back: A read, B write parked during A, C stalled while the slot is full.
    step(di(1, 0, 4'hF, 32'h0000_0200, 32'h0, 0, 32'h0), idl);
    step(di(1, 1, 4'hF, 32'h0000_0300, 32'h1234_5678, 0, 32'h0), bus(1, 0, 4'hF, 32'h0000_0200, 32'h0));
    step(di(1, 0, 4'hF, 32'h0000_0700, 32'h0, 1, 32'hA0A0_0001), bus(0, 0, 4'hF, 32'h0000_0200, 32'h0));
    step(di(1, 0, 4'hF, 32'h0000_0700, 32'h0, 0, 32'h0), resp(0, 1, 0, 32'hA0A0_0001));
    step(di(1, 0, 4'hF, 32'h0000_0700, 32'h0, 1, 32'h0), bus(1, 1, 4'hF, 32'h0000_0300, 32'h1234_5678));
    step(nop, resp(0, 0, 0, 32'h0));
    step(di(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h7777_0007), bus(1, 0, 4'hF, 32'h0000_0700, 32'h0));
    step(nop, resp(1, 1, 0, 32'h7777_0007));
    step(nop, idl);

    // Reset mid-WAIT with the pending slot full: everything is dropped silently.
    step(di(1, 0, 4'hF, 32'h0000_0800, 32'h0, 0, 32'h0), idl);
    step(di(1, 1, 4'hF, 32'h0000_0900, 32'h0000_9999, 0, 32'h0), bus(1, 0, 4'hF, 32'h0000_0800, 32'h0));
    step(rst_row, bus(0, 0, 4'hF, 32'h0000_0800, 32'h0));
    step(nop, idl);
    check("rst2_wb_addr", wb_addr_o, 32'h0);
    step(nop, idl);
    step(nop, idl);
    step(di(1, 0, 4'hF, 32'h0000_0A00, 32'h0, 0, 32'h0), idl);
    step(di(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hBBBB_0001), bus(1, 0, 4'hF, 32'h0000_0A00, 32'h0));
    step(nop, resp(1, 1, 0, 32'hBBBB_0001));
    step(nop, idl);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
